ram_bridge_tx: RTL and testbench

//   Host-bound framer for the RAM bridge: the reply path paired with the host-to-FPGA command receiver.

---
 rtl/ram_bridge_tx_pkg.sv | 30 +++
 rtl/ram_bridge_tx_if.sv | 26 ++
 rtl/ram_bridge_tx.sv | 129 ++++++++++++
 tb/tb_ram_bridge_tx.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/ram_bridge_tx_pkg.sv
// Shared constants and types for the RAM bridge framer: command bytes, payload size,
// transmit state encoding and the payload byte selector.
package ram_bridge_pkg;

    localparam logic [7:0] CMD_WRITE = 8'h57;  // "W"
    localparam logic [7:0] CMD_RESET = 8'h52;  // "R"
    localparam logic [7:0] CMD_HALT  = 8'h48;  // "H"
    localparam logic [7:0] CMD_START = 8'h53;  // "S"
    localparam logic [7:0] RSP_DATA  = 8'h44;  // "D"
    localparam logic [7:0] RSP_ACK   = 8'h4B;  // "K"

    localparam int unsigned PAYLOAD_BYTES = 8;

    typedef enum logic [1:0] {
        IDLE,
        HEADER,
        PAYLOAD,
        CHECK
    } tx_state_t;

    // Payload byte k: 0..3 are addr LSB-first, 4..7 are data LSB-first.
    function automatic logic [7:0] payload_byte(input logic [31:0] addr,
                                                input logic [31:0] data,
                                                input logic [2:0]  k);
        logic [63:0] w_all;
        w_all = {data, addr};
        return w_all[{k, 3'b000} +: 8];
    endfunction

endpackage

// File: rtl/ram_bridge_tx_if.sv
// Frame request and outgoing byte stream of the RAM bridge framer.
// slave: the framer itself; master: the requester / downstream UART side.
interface ram_bridge_tx_if;

    logic [7:0]  cmd_in;
    logic [31:0] addr_in;
    logic [31:0] data_in;
    logic        payload_in;
    logic        valid_in;
    logic        ready_out;
    logic [7:0]  data_out;
    logic        valid_out;
    logic        ready_in;
    logic        busy_out;

    modport slave (
        input  cmd_in, addr_in, data_in, payload_in, valid_in, ready_in,
        output ready_out, data_out, valid_out, busy_out
    );

    modport master (
        output cmd_in, addr_in, data_in, payload_in, valid_in, ready_in,
        input  ready_out, data_out, valid_out, busy_out
    );

endinterface

// File: rtl/ram_bridge_tx.sv
// Host-bound framer: latches one response frame and serializes it as header,
// addr LSB-first, data LSB-first and an optional XOR checksum byte.
module ram_bridge_tx
    import ram_bridge_pkg::*;
#(
    parameter bit CHECKSUM_EN = 1'b0
) (
    input  logic           clk_in,
    input  logic           rst_in,
    ram_bridge_tx_if.slave bus
);

    localparam logic [3:0] LAST_IDX = 4'(PAYLOAD_BYTES - 1);

    tx_state_t   r_state;
    logic [7:0]  r_cmd;
    logic [31:0] r_addr;
    logic [31:0] r_data;
    logic        r_payload;
    logic [3:0]  r_idx;
    logic [7:0]  r_csum;
    logic [7:0]  r_dout;
    logic        r_vout;
    logic        r_rdy;
    logic        r_busy;

    logic        w_accept;
    logic        w_xfer;
    logic [3:0]  w_next_idx;
    logic [7:0]  w_next_byte;
    logic [7:0]  w_first_byte;

    assign w_accept     = r_rdy && bus.valid_in;
    assign w_xfer       = r_vout && bus.ready_in;
    assign w_next_idx   = r_idx + 4'd1;
    assign w_next_byte  = payload_byte(r_addr, r_data, w_next_idx[2:0]);
    assign w_first_byte = payload_byte(r_addr, r_data, 3'd0);

    assign bus.ready_out = r_rdy;
    assign bus.data_out  = r_dout;
    assign bus.valid_out = r_vout;
    assign bus.busy_out  = r_busy;

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_state   <= IDLE;
            r_cmd     <= '0;
            r_addr    <= '0;
            r_data    <= '0;
            r_payload <= 1'b0;
            r_idx     <= '0;
            r_csum    <= '0;
            r_dout    <= '0;
            r_vout    <= 1'b0;
            r_rdy     <= 1'b1;
            r_busy    <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_state   <= HEADER;
                        r_cmd     <= bus.cmd_in;
                        r_addr    <= bus.addr_in;
                        r_data    <= bus.data_in;
                        r_payload <= bus.payload_in;
                        r_idx     <= '0;
                        r_csum    <= '0;
                        r_dout    <= bus.cmd_in;
                        r_vout    <= 1'b1;
                        r_rdy     <= 1'b0;
                        r_busy    <= 1'b1;
                    end
                end

                HEADER: begin
                    if (w_xfer) begin
                        if (r_payload) begin
                            r_state <= PAYLOAD;
                            r_dout  <= w_first_byte;
                        end else begin
                            r_state <= IDLE;
                            r_vout  <= 1'b0;
                            r_rdy   <= 1'b1;
                            r_busy  <= 1'b0;
                        end
                    end
                end

                PAYLOAD: begin
                    if (w_xfer) begin
                        r_csum <= r_csum ^ r_dout;
                        if (r_idx == LAST_IDX) begin
                            if (CHECKSUM_EN) begin
                                // Fold in the last payload byte directly; r_csum is one byte behind.
                                r_state <= CHECK;
                                r_dout  <= r_cmd ^ r_csum ^ r_dout;
                            end else begin
                                r_state <= IDLE;
                                r_vout  <= 1'b0;
                                r_rdy   <= 1'b1;
                                r_busy  <= 1'b0;
                            end
                        end else begin
                            r_idx  <= w_next_idx;
                            r_dout <= w_next_byte;
                        end
                    end
                end

                CHECK: begin
                    if (w_xfer) begin
                        r_state <= IDLE;
                        r_vout  <= 1'b0;
                        r_rdy   <= 1'b1;
                        r_busy  <= 1'b0;
                    end
                end

                default: begin
                    r_state <= IDLE;
                    r_vout  <= 1'b0;
                    r_rdy   <= 1'b1;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ram_bridge_tx.sv
// Directed bench for ram_bridge_tx: table of frames against both checksum settings,
// plus hand sequences for busy rejection and reset behaviour.
module tb_ram_bridge_tx;
    import ram_bridge_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    ram_bridge_tx_if bus0 ();
    ram_bridge_tx_if bus1 ();

    ram_bridge_tx #(.CHECKSUM_EN(1'b0)) u_dut0 (.clk_in(clk), .rst_in(rst), .bus(bus0.slave));
    ram_bridge_tx #(.CHECKSUM_EN(1'b1)) u_dut1 (.clk_in(clk), .rst_in(rst), .bus(bus1.slave));

    logic [7:0]  t_cmd = '0;
    logic [31:0] t_addr = '0;
    logic [31:0] t_data = '0;
    logic        t_payload = 1'b0;
    logic        t_v0 = 1'b0;
    logic        t_v1 = 1'b0;
    logic        t_rin = 1'b1;
    int          sel = 0;

    assign bus0.cmd_in = t_cmd;      assign bus1.cmd_in = t_cmd;
    assign bus0.addr_in = t_addr;    assign bus1.addr_in = t_addr;
    assign bus0.data_in = t_data;    assign bus1.data_in = t_data;
    assign bus0.payload_in = t_payload; assign bus1.payload_in = t_payload;
    assign bus0.valid_in = t_v0;     assign bus1.valid_in = t_v1;
    assign bus0.ready_in = t_rin;    assign bus1.ready_in = t_rin;

    logic [7:0] w_dout;
    logic       w_vout, w_rdy, w_busy;
    assign w_dout = (sel != 0) ? bus1.data_out  : bus0.data_out;
    assign w_vout = (sel != 0) ? bus1.valid_out : bus0.valid_out;
    assign w_rdy  = (sel != 0) ? bus1.ready_out : bus0.ready_out;
    assign w_busy = (sel != 0) ? bus1.busy_out  : bus0.busy_out;

    typedef struct {
        int          sel;
        logic [7:0]  cmd;
        logic [31:0] addr;
        logic [31:0] data;
        logic        payload;
        int          pat;   // 0: ready_in always high; 1: ready_in 1,0,0 repeating
        int          n;
        logic [79:0] exp;   // byte 0 in bits [7:0]
    } vec_t;

    vec_t vecs [6];
    int   tests = 0;
    int   fails = 0;
    logic [7:0] cap [16];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic set_valid(input logic b);
        if (sel != 0) t_v1 = b;
        else          t_v0 = b;
    endtask

    // Entered and left on a negedge. pulse_at >= 0 raises valid_in while that byte is on the wire.
    task automatic run_frame(input vec_t v, input int pulse_at);
        int   ncap, vcyc;
        bit   stalled, done;
        logic [7:0] prev;
        logic [79:0] e;
        sel = v.sel;
        t_cmd = v.cmd; t_addr = v.addr; t_data = v.data; t_payload = v.payload;
        t_rin = 1'b1;
        chk("pre_ready", 32'(w_rdy), 32'd1);
        set_valid(1'b1);
        @(posedge clk);
        @(negedge clk);
        set_valid(1'b0);
        // Scramble inputs to show the frame was latched on accept.
        t_cmd = 8'hA5; t_addr = 32'hFFFF_FFFF; t_data = 32'h0; t_payload = ~v.payload;
        chk("latency_valid", 32'(w_vout), 32'd1);
        chk("accept_ready_low", 32'(w_rdy), 32'd0);
        ncap = 0; vcyc = 0; stalled = 0; done = 0; prev = '0;
        for (int c = 0; c < 200 && !done; c++) begin
            if (w_vout) begin
                vcyc++;
                if (stalled) chk("stall_hold", 32'(w_dout), 32'(prev));
                if (ncap == pulse_at) begin
                    set_valid(1'b1);
                    chk("busy_ready_low", 32'(w_rdy), 32'd0);
                end else begin
                    set_valid(1'b0);
                end
                t_rin = (v.pat == 0) ? 1'b1 : ((c % 3) == 0);
                if (t_rin) begin
                    if (ncap < 16) cap[ncap] = w_dout;
                    ncap++;
                    stalled = 0;
                end else begin
                    stalled = 1;
                    prev = w_dout;
                end
                @(negedge clk);
            end else begin
                done = 1;
            end
        end
        set_valid(1'b0);
        t_rin = 1'b1;
        if (!done) chk("frame_timeout", 32'd0, 32'd1);
        chk("byte_count", 32'(ncap), 32'(v.n));
        e = v.exp;
        for (int i = 0; i < v.n && i < 16 && i < ncap; i++)
            chk($sformatf("byte%0d", i), 32'(cap[i]), 32'(e[8*i +: 8]));
        if (v.pat == 0) chk("consecutive", 32'(vcyc), 32'(v.n));
        chk("post_ready", 32'(w_rdy), 32'd1);
        chk("post_busy", 32'(w_busy), 32'd0);
    endtask

    initial begin
        vecs[0] = '{0, RSP_DATA, 32'h1234_5678, 32'hDEAD_BEEF, 1'b1, 0, 9,
                    80'h00_DE_AD_BE_EF_12_34_56_78_44};
        vecs[1] = '{0, RSP_ACK, 32'h1111_1111, 32'h2222_2222, 1'b0, 0, 1, 80'h4B};
        vecs[2] = '{0, RSP_DATA, 32'h1234_5678, 32'hDEAD_BEEF, 1'b1, 1, 9,
                    80'h00_DE_AD_BE_EF_12_34_56_78_44};
        vecs[3] = '{1, 8'h44, 32'h0000_0000, 32'h0000_00FF, 1'b1, 0, 10,
                    80'hBB_00_00_00_FF_00_00_00_00_44};
        vecs[4] = '{1, RSP_ACK, 32'h3333_3333, 32'h4444_4444, 1'b0, 0, 1, 80'h4B};
        vecs[5] = '{1, RSP_DATA, 32'h1234_5678, 32'hDEAD_BEEF, 1'b1, 1, 10,
                    80'h6E_DE_AD_BE_EF_12_34_56_78_44};

        rst = 1'b1;
        repeat (3) @(negedge clk);
        for (int s = 0; s < 2; s++) begin
            sel = s;
            #0;
            chk("rst_data", 32'(w_dout), 32'd0);
            chk("rst_valid", 32'(w_vout), 32'd0);
            chk("rst_busy", 32'(w_busy), 32'd0);
            chk("rst_ready", 32'(w_rdy), 32'd1);
        end
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 6; i++) begin
            run_frame(vecs[i], -1);
            @(negedge clk);
        end

        // Busy rejection: valid_in pulsed while byte 3 is presented.
        run_frame(vecs[0], 2);
        for (int c = 0; c < 6; c++) begin
            if (w_vout) begin
                chk("no_second_frame", 32'(w_vout), 32'd0);
                break;
            end
            @(negedge clk);
        end
        chk("idle_after_reject", 32'(w_vout), 32'd0);

        // Reset mid-frame after four bytes have transferred.
        sel = 0;
        t_cmd = RSP_DATA; t_addr = 32'h1234_5678; t_data = 32'hDEAD_BEEF; t_payload = 1'b1;
        t_rin = 1'b1;
        set_valid(1'b1);
        @(posedge clk);
        @(negedge clk);
        set_valid(1'b0);
        repeat (4) @(negedge clk);
        chk("mid_byte5", 32'(w_dout), 32'h12);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midrst_valid", 32'(w_vout), 32'd0);
        chk("midrst_ready", 32'(w_rdy), 32'd1);
        chk("midrst_busy", 32'(w_busy), 32'd0);
        @(negedge clk);
        chk("midrst_no_resume", 32'(w_vout), 32'd0);
        run_frame(vecs[0], -1);
        @(negedge clk);

        // Reset and valid_in together: reset wins.
        sel = 0;
        t_cmd = RSP_ACK; t_payload = 1'b0;
        rst = 1'b1;
        set_valid(1'b1);
        @(negedge clk);
        rst = 1'b0;
        set_valid(1'b0);
        chk("rstvalid_valid", 32'(w_vout), 32'd0);
        chk("rstvalid_ready", 32'(w_rdy), 32'd1);
        @(negedge clk);
        chk("rstvalid_no_frame", 32'(w_vout), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
